// File: rtl/m_virtio_mmio_dev.sv
// virtio-mmio (v2) device register block: NUM_QUEUES virtqueues with 64-bit ring addresses,
// coalesced notify pending bits handed out round-robin, and ISR/ACK interrupt handling.
module m_virtio_mmio_dev #(
    parameter int unsigned DEVICE_ID     = 3,
    parameter logic [63:0] FEATURES      = 64'h1,
    parameter int unsigned NUM_QUEUES    = 2,
    parameter int unsigned QUEUE_NUM_MAX = 8,
    parameter int unsigned IRQ_NUM       = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        w_we,
    input  logic [7:0]  w_addr,
    input  logic [31:0] w_wdata,
    output logic [31:0] w_rdata,
    input  logic [31:0] w_iirq,
    output logic [31:0] w_oirq,
    output logic        w_irq,
    input  logic        w_used_upd,
    input  logic        w_cfg_chg,
    output logic        w_ntf_valid,
    output logic [2:0]  w_ntf_qidx,
    input  logic        w_ntf_ready,
    input  logic [2:0]  w_mc_qidx,
    output logic [15:0] w_mc_num,
    output logic        w_mc_rdy,
    output logic [63:0] w_mc_desc,
    output logic [63:0] w_mc_avail,
    output logic [63:0] w_mc_used
);
    localparam int unsigned MaxQ = 8;

    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     dev_feat_sel_q, dev_feat_sel_d;
    logic [31:0]     drv_feat_sel_q, drv_feat_sel_d;
    logic [31:0]     drv_feat_q [2];
    logic [31:0]     drv_feat_d [2];
    logic [31:0]     queue_sel_q, queue_sel_d;
    logic [31:0]     status_q, status_d;
    logic [31:0]     cfg_gen_q, cfg_gen_d;
    logic [1:0]      isr_q, isr_d;
    logic [15:0]     num_q [MaxQ];
    logic [15:0]     num_d [MaxQ];
    logic [63:0]     desc_q [MaxQ];
    logic [63:0]     desc_d [MaxQ];
    logic [63:0]     avail_q [MaxQ];
    logic [63:0]     avail_d [MaxQ];
    logic [63:0]     used_q [MaxQ];
    logic [63:0]     used_d [MaxQ];
    logic [MaxQ-1:0] rdy_q, rdy_d;
    logic [MaxQ-1:0] pend_q, pend_d;
    logic [2:0]      rr_q, rr_d;
    logic            ntf_valid_q, ntf_valid_d;
    logic [2:0]      ntf_qidx_q, ntf_qidx_d;

    logic       sel_ok;
    logic [2:0] qs;
    logic       q_wr_ok;
    logic       ntf_ok;
    logic       accept;
    logic       dev_rst;

    // First pending queue at or after r, wrapping at NUM_QUEUES.
    function automatic logic [2:0] pick(input logic [MaxQ-1:0] p, input logic [2:0] r);
        logic [2:0]  res;
        logic        found;
        int unsigned idx;
        res   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
            idx = (32'(r) + k) % NUM_QUEUES;
            if (!found && p[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign sel_ok  = queue_sel_q < NUM_QUEUES;
    assign qs      = queue_sel_q[2:0];
    assign q_wr_ok = sel_ok && !rdy_q[qs];
    assign ntf_ok  = (w_wdata < NUM_QUEUES) && rdy_q[w_wdata[2:0]];
    assign accept  = ntf_valid_q && w_ntf_ready;
    assign dev_rst = w_we && (w_addr == 8'h70) && (w_wdata == 32'h0);

    always_comb begin
        dev_feat_sel_d = dev_feat_sel_q;
        drv_feat_sel_d = drv_feat_sel_q;
        drv_feat_d     = drv_feat_q;
        queue_sel_d    = queue_sel_q;
        status_d       = status_q;
        cfg_gen_d      = cfg_gen_q;
        isr_d          = isr_q;
        num_d          = num_q;
        desc_d         = desc_q;
        avail_d        = avail_q;
        used_d         = used_q;
        rdy_d          = rdy_q;
        pend_d         = pend_q;
        rr_d           = rr_q;
        ntf_valid_d    = ntf_valid_q;
        ntf_qidx_d     = ntf_qidx_q;

        if (accept) begin
            pend_d[ntf_qidx_q] = 1'b0;
            rr_d = (32'(ntf_qidx_q) == NUM_QUEUES - 1) ? 3'd0 : ntf_qidx_q + 3'd1;
        end

        if (w_we) begin
            case (w_addr)
                8'h14: dev_feat_sel_d = w_wdata;
                8'h20: if (drv_feat_sel_q < 32'd2) drv_feat_d[drv_feat_sel_q[0]] = w_wdata;
                8'h24: drv_feat_sel_d = w_wdata;
                8'h30: queue_sel_d = w_wdata;
                8'h38: begin
                    if (q_wr_ok && w_wdata != 32'h0 && w_wdata <= QUEUE_NUM_MAX) begin
                        num_d[qs] = w_wdata[15:0];
                    end
                end
                8'h44: if (sel_ok) rdy_d[qs] = w_wdata[0];
                8'h50: if (ntf_ok) pend_d[w_wdata[2:0]] = 1'b1;
                8'h64: isr_d = isr_q & ~w_wdata[1:0];
                8'h70: status_d = w_wdata;
                8'h80: if (q_wr_ok) desc_d[qs][31:0] = w_wdata;
                8'h84: if (q_wr_ok) desc_d[qs][63:32] = w_wdata;
                8'h90: if (q_wr_ok) avail_d[qs][31:0] = w_wdata;
                8'h94: if (q_wr_ok) avail_d[qs][63:32] = w_wdata;
                8'ha0: if (q_wr_ok) used_d[qs][31:0] = w_wdata;
                8'ha4: if (q_wr_ok) used_d[qs][63:32] = w_wdata;
                default: ;
            endcase
        end

        // Event sets are applied after ACK so a same-cycle set wins.
        if (w_used_upd) isr_d[0] = 1'b1;
        if (w_cfg_chg) begin
            isr_d[1]  = 1'b1;
            cfg_gen_d = cfg_gen_q + 32'd1;
        end

        // Offer is re-chosen only when idle or on accept, so qidx holds while stalled.
        if (!ntf_valid_q || accept) begin
            ntf_valid_d = |pend_d;
            ntf_qidx_d  = pick(pend_d, rr_d);
        end

        if (dev_rst) begin
            dev_feat_sel_d = '0;
            drv_feat_sel_d = '0;
            drv_feat_d     = '{default: '0};
            queue_sel_d    = '0;
            isr_d          = '0;
            num_d          = '{default: '0};
            desc_d         = '{default: '0};
            avail_d        = '{default: '0};
            used_d         = '{default: '0};
            rdy_d          = '0;
            pend_d         = '0;
            rr_d           = '0;
            ntf_valid_d    = 1'b0;
            ntf_qidx_d     = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        case (w_addr)
            8'h00: rdata_d = 32'h7472_6976;
            8'h04: rdata_d = 32'd2;
            8'h08: rdata_d = DEVICE_ID;
            8'h0c: rdata_d = 32'h0000_ffff;
            8'h10: rdata_d = dev_feat_sel_q[0] ? FEATURES[63:32] : FEATURES[31:0];
            8'h34: if (sel_ok) rdata_d = QUEUE_NUM_MAX;
            8'h38: if (sel_ok) rdata_d = {16'h0, num_q[qs]};
            8'h44: if (sel_ok) rdata_d = {31'h0, rdy_q[qs]};
            8'h60: rdata_d = {30'h0, isr_q};
            8'h70: rdata_d = status_q;
            8'h80: if (sel_ok) rdata_d = desc_q[qs][31:0];
            8'h84: if (sel_ok) rdata_d = desc_q[qs][63:32];
            8'h90: if (sel_ok) rdata_d = avail_q[qs][31:0];
            8'h94: if (sel_ok) rdata_d = avail_q[qs][63:32];
            8'ha0: if (sel_ok) rdata_d = used_q[qs][31:0];
            8'ha4: if (sel_ok) rdata_d = used_q[qs][63:32];
            8'hfc: rdata_d = cfg_gen_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q        <= '0;
            dev_feat_sel_q <= '0;
            drv_feat_sel_q <= '0;
            drv_feat_q[0]  <= '0;
            drv_feat_q[1]  <= '0;
            queue_sel_q    <= '0;
            status_q       <= '0;
            cfg_gen_q      <= '0;
            isr_q          <= '0;
            rdy_q          <= '0;
            pend_q         <= '0;
            rr_q           <= '0;
            ntf_valid_q    <= 1'b0;
            ntf_qidx_q     <= '0;
            for (int i = 0; i < MaxQ; i++) begin
                num_q[i]   <= '0;
                desc_q[i]  <= '0;
                avail_q[i] <= '0;
                used_q[i]  <= '0;
            end
        end else begin
            rdata_q        <= rdata_d;
            dev_feat_sel_q <= dev_feat_sel_d;
            drv_feat_sel_q <= drv_feat_sel_d;
            drv_feat_q     <= drv_feat_d;
            queue_sel_q    <= queue_sel_d;
            status_q       <= status_d;
            cfg_gen_q      <= cfg_gen_d;
            isr_q          <= isr_d;
            rdy_q          <= rdy_d;
            pend_q         <= pend_d;
            rr_q           <= rr_d;
            ntf_valid_q    <= ntf_valid_d;
            ntf_qidx_q     <= ntf_qidx_d;
            num_q          <= num_d;
            desc_q         <= desc_d;
            avail_q        <= avail_d;
            used_q         <= used_d;
        end
    end

    always_comb begin
        w_oirq              = w_iirq;
        w_oirq[IRQ_NUM - 1] = w_irq;
    end

    assign w_irq       = |isr_q;
    assign w_rdata     = rdata_q;
    assign w_ntf_valid = ntf_valid_q;
    assign w_ntf_qidx  = ntf_qidx_q;
    assign w_mc_num    = num_q[w_mc_qidx];
    assign w_mc_rdy    = rdy_q[w_mc_qidx];
    assign w_mc_desc   = desc_q[w_mc_qidx];
    assign w_mc_avail  = avail_q[w_mc_qidx];
    assign w_mc_used   = used_q[w_mc_qidx];

endmodule

// File: tb/tb_m_virtio_mmio_dev.sv
// Self-checking bench for m_virtio_mmio_dev: register-map vector table plus directed
// sequences for notify arbitration, ISR/ACK, device reset and async reset.
module tb_m_virtio_mmio_dev;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        w_we = 1'b0;
    logic [7:0]  w_addr = '0;
    logic [31:0] w_wdata = '0;
    logic [31:0] w_rdata;
    logic [31:0] w_iirq = 32'hA5A5_0000;
    logic [31:0] w_oirq;
    logic        w_irq;
    logic        w_used_upd = 1'b0;
    logic        w_cfg_chg = 1'b0;
    logic        w_ntf_valid;
    logic [2:0]  w_ntf_qidx;
    logic        w_ntf_ready = 1'b0;
    logic [2:0]  w_mc_qidx = '0;
    logic [15:0] w_mc_num;
    logic        w_mc_rdy;
    logic [63:0] w_mc_desc;
    logic [63:0] w_mc_avail;
    logic [63:0] w_mc_used;

    m_virtio_mmio_dev dut (
        .CLK        (CLK),
        .RST        (RST),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_wdata    (w_wdata),
        .w_rdata    (w_rdata),
        .w_iirq     (w_iirq),
        .w_oirq     (w_oirq),
        .w_irq      (w_irq),
        .w_used_upd (w_used_upd),
        .w_cfg_chg  (w_cfg_chg),
        .w_ntf_valid(w_ntf_valid),
        .w_ntf_qidx (w_ntf_qidx),
        .w_ntf_ready(w_ntf_ready),
        .w_mc_qidx  (w_mc_qidx),
        .w_mc_num   (w_mc_num),
        .w_mc_rdy   (w_mc_rdy),
        .w_mc_desc  (w_mc_desc),
        .w_mc_avail (w_mc_avail),
        .w_mc_used  (w_mc_used)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        do_chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        w_we    = 1'b1;
        w_addr  = a;
        w_wdata = d;
        step();
        w_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        w_addr = a;
        step();
        chk(name, 64'(w_rdata), 64'(exp));
    endtask

    task automatic vec(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic c, input logic [31:0] e, input string n);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.do_chk = c; v.exp = e; v.name = n;
        tbl.push_back(v);
    endtask

    initial begin
        int          acc;
        logic [2:0]  got [2];

        vec(1'b0, 8'h00, 32'h0, 1'b1, 32'h7472_6976, "magic");
        vec(1'b0, 8'h04, 32'h0, 1'b1, 32'd2, "version");
        vec(1'b0, 8'h08, 32'h0, 1'b1, 32'd3, "device_id");
        vec(1'b0, 8'h0c, 32'h0, 1'b1, 32'h0000_ffff, "vendor");
        vec(1'b0, 8'h10, 32'h0, 1'b1, 32'h1, "features_lo");
        vec(1'b1, 8'h14, 32'h1, 1'b0, 32'h0, "");
        vec(1'b0, 8'h10, 32'h0, 1'b1, 32'h0, "features_hi");
        vec(1'b0, 8'h34, 32'h0, 1'b1, 32'd8, "num_max_q0");
        vec(1'b1, 8'h30, 32'd5, 1'b0, 32'h0, "");
        vec(1'b0, 8'h34, 32'h0, 1'b1, 32'h0, "num_max_sel5");
        vec(1'b1, 8'h30, 32'd1, 1'b0, 32'h0, "");
        vec(1'b1, 8'h80, 32'h8000_0000, 1'b0, 32'h0, "");
        vec(1'b1, 8'h84, 32'h1, 1'b0, 32'h0, "");
        vec(1'b1, 8'h38, 32'd8, 1'b0, 32'h0, "");
        vec(1'b1, 8'h38, 32'd9, 1'b0, 32'h0, "");
        vec(1'b1, 8'h38, 32'd0, 1'b0, 32'h0, "");
        vec(1'b0, 8'h38, 32'h0, 1'b1, 32'd8, "num_after_bad_writes");
        vec(1'b1, 8'h44, 32'h1, 1'b0, 32'h0, "");
        vec(1'b1, 8'h38, 32'd4, 1'b0, 32'h0, "");
        vec(1'b0, 8'h38, 32'h0, 1'b1, 32'd8, "num_locked_by_ready");
        vec(1'b1, 8'h80, 32'h0, 1'b0, 32'h0, "");
        vec(1'b0, 8'h80, 32'h0, 1'b1, 32'h8000_0000, "desc_lo_locked");
        vec(1'b0, 8'h84, 32'h0, 1'b1, 32'h1, "desc_hi");
        vec(1'b0, 8'h44, 32'h0, 1'b1, 32'h1, "queue_ready_q1");
        vec(1'b0, 8'h60, 32'h0, 1'b1, 32'h0, "isr_idle");
        vec(1'b0, 8'hfc, 32'h0, 1'b1, 32'h0, "cfg_gen_reset");

        // Reset state
        step();
        step();
        chk("rst_rdata", 64'(w_rdata), 64'h0);
        chk("rst_irq", 64'(w_irq), 64'h0);
        chk("rst_ntf_valid", 64'(w_ntf_valid), 64'h0);
        chk("rst_oirq", 64'(w_oirq), 64'hA5A5_0000);
        RST = 1'b0;
        step();

        foreach (tbl[i]) begin
            w_we    = tbl[i].we;
            w_addr  = tbl[i].addr;
            w_wdata = tbl[i].wdata;
            step();
            w_we = 1'b0;
            if (tbl[i].do_chk) chk(tbl[i].name, 64'(w_rdata), 64'(tbl[i].exp));
        end

        w_mc_qidx = 3'd1;
        #1;
        chk("mc_num_q1", 64'(w_mc_num), 64'd8);
        chk("mc_desc_q1", w_mc_desc, 64'h1_8000_0000);
        chk("mc_rdy_q1", 64'(w_mc_rdy), 64'h1);

        // q0 setup, Status nonzero
        wr(8'h30, 32'd0);
        wr(8'h38, 32'd4);
        wr(8'h44, 32'd1);
        wr(8'h70, 32'hF);
        rd_chk("status", 8'h70, 32'hF);

        // Notify q0,q1,q0 while stalled: merges to two services
        wr(8'h50, 32'd0);
        wr(8'h50, 32'd1);
        wr(8'h50, 32'd0);
        chk("ntf_valid_stalled", 64'(w_ntf_valid), 64'h1);
        chk("ntf_qidx_first", 64'(w_ntf_qidx), 64'h0);
        acc = 0;
        got[0] = '1;
        got[1] = '1;
        w_ntf_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (w_ntf_valid) begin
                if (acc < 2) got[acc] = w_ntf_qidx;
                acc++;
            end
            step();
        end
        w_ntf_ready = 1'b0;
        chk("accept_count", 64'(acc), 64'd2);
        chk("accept0_qidx", 64'(got[0]), 64'h0);
        chk("accept1_qidx", 64'(got[1]), 64'h1);

        // Dropped notifies: un-ready queue and out-of-range index
        wr(8'h30, 32'd1);
        wr(8'h44, 32'd0);
        wr(8'h50, 32'd1);
        chk("drop_unready", 64'(w_ntf_valid), 64'h0);
        wr(8'h50, 32'd7);
        chk("drop_range", 64'(w_ntf_valid), 64'h0);
        w_mc_qidx = 3'd1;
        #1;
        chk("mc_rdy_q1_cleared", 64'(w_mc_rdy), 64'h0);
        wr(8'h44, 32'd1);

        // Accept q0 with same-cycle re-notify of q0: stays pending, rr moves to q1
        wr(8'h50, 32'd0);
        wr(8'h50, 32'd1);
        chk("rr_pre_qidx", 64'(w_ntf_qidx), 64'h0);
        w_we = 1'b1; w_addr = 8'h50; w_wdata = 32'd0; w_ntf_ready = 1'b1;
        step();
        w_we = 1'b0; w_ntf_ready = 1'b0;
        chk("setwins_valid", 64'(w_ntf_valid), 64'h1);
        chk("rr_next_q1", 64'(w_ntf_qidx), 64'h1);
        w_ntf_ready = 1'b1;
        step();
        w_ntf_ready = 1'b0;
        chk("q0_still_pending", 64'(w_ntf_valid), 64'h1);
        chk("rr_wrap_q0", 64'(w_ntf_qidx), 64'h0);
        w_ntf_ready = 1'b1;
        step();
        w_ntf_ready = 1'b0;
        chk("drained", 64'(w_ntf_valid), 64'h0);

        // ISR: same-cycle used_upd and ACK -> set wins
        w_we = 1'b1; w_addr = 8'h64; w_wdata = 32'h1; w_used_upd = 1'b1;
        step();
        w_we = 1'b0; w_used_upd = 1'b0;
        chk("isr_set_wins_irq", 64'(w_irq), 64'h1);
        chk("oirq_set", 64'(w_oirq), 64'hA5A5_0001);
        rd_chk("isr_read1", 8'h60, 32'h1);
        wr(8'h64, 32'h1);
        chk("irq_acked", 64'(w_irq), 64'h0);
        chk("oirq_clr", 64'(w_oirq), 64'hA5A5_0000);

        // Device reset with q0 pending and ISR=3
        w_cfg_chg = 1'b1;
        step();
        w_cfg_chg = 1'b0;
        w_used_upd = 1'b1;
        step();
        w_used_upd = 1'b0;
        rd_chk("isr_read3", 8'h60, 32'h3);
        rd_chk("cfg_gen1", 8'hfc, 32'h1);
        wr(8'h50, 32'd0);
        chk("pre_devrst_valid", 64'(w_ntf_valid), 64'h1);
        wr(8'h70, 32'h0);
        chk("devrst_valid", 64'(w_ntf_valid), 64'h0);
        chk("devrst_irq", 64'(w_irq), 64'h0);
        rd_chk("devrst_isr", 8'h60, 32'h0);
        rd_chk("devrst_qready", 8'h44, 32'h0);
        rd_chk("devrst_cfg_kept", 8'hfc, 32'h1);
        rd_chk("devrst_status", 8'h70, 32'h0);
        w_mc_qidx = 3'd1;
        #1;
        chk("devrst_desc_q1", w_mc_desc, 64'h0);
        chk("devrst_num_q1", 64'(w_mc_num), 64'h0);

        // Async reset mid-handshake
        wr(8'h44, 32'd1);
        wr(8'h50, 32'd0);
        w_cfg_chg = 1'b1;
        step();
        w_cfg_chg = 1'b0;
        chk("pre_rst_valid", 64'(w_ntf_valid), 64'h1);
        w_ntf_ready = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 64'(w_ntf_valid), 64'h0);
        chk("async_rst_irq", 64'(w_irq), 64'h0);
        RST = 1'b0;
        step();
        rd_chk("async_rst_cfg_gen", 8'hfc, 32'h0);
        rd_chk("async_rst_qready", 8'h44, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
